fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning instruction-memory byte-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  meaning fetch enable; low pauses new fetches while the queue drains.
REQ-006 SHALL have port imem_addr  output  ADDR_W  meaning byte address to the combinational instruction memory.
REQ-007 SHALL have port imem_dout  input  32  meaning little-endian instruction word read at imem_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  meaning branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  ADDR_W  meaning redirect target address.
REQ-010 SHALL have port inst_valid  output  1  meaning queue head holds a valid instruction.
REQ-011 SHALL have port inst_ready  input  1  meaning decode accepts the head this cycle.
REQ-012 SHALL have port inst_word  output  32  meaning head instruction word.
REQ-013 SHALL have port inst_pc  output  ADDR_W  meaning head instruction address.
REQ-014 SHALL have port fault  output  1  meaning sticky misaligned-redirect flag (when REQ-030 compiled in).

Function
REQ-015 SHALL hold PC register pc; imem_addr SHALL equal pc combinationally.
REQ-016 SHALL implement states IDLE, RUN, FAULT; IDLE->RUN when en=1; RUN->IDLE when en=0 and no redirect; any->FAULT per REQ-030; FAULT exits only by reset.
REQ-017 SHALL fetch in a cycle when state=RUN, en=1, redirect_valid=0 and queue not full or head popped that cycle: push {pc, imem_dout}, pc <= pc+4 modulo 2^ADDR_W.
REQ-018 SHALL wrap pc from 2^ADDR_W-4 to 0 with no gap or stall.
REQ-019 SHALL buffer fetched entries in a 2-entry FIFO; inst_valid = FIFO non-empty; pop on inst_valid & inst_ready.
REQ-020 SHALL, when full with simultaneous pop, push and pop in the same cycle, sustaining one instruction per cycle.
REQ-021 SHALL, on redirect_valid=1, flush the FIFO, set pc <= redirect_pc, and fetch nothing that cycle; any head accepted the same cycle is discarded (redirect wins over push and pop).
REQ-022 SHALL deliver the redirect target at inst_valid two cycles after the redirect edge minimum (one fetch cycle, one queue cycle).
REQ-023 SHALL keep inst_word/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-024 SHALL present inst_word=32'h00000013 (NOP) when inst_valid=0.
REQ-025 SHALL, in FAULT, stop fetching, flush the FIFO and hold inst_valid=0.

Reset
REQ-026 SHALL on rst=1 asynchronously set pc=RESET_PC, state=IDLE, FIFO empty, inst_valid=0, inst_pc=0, inst_word=NOP, fault=0.
REQ-027 SHALL on reset mid-operation discard all queued entries; first fetch after release is RESET_PC.
REQ-028 SHALL not fetch in the first edge after rst deassertion (IDLE->RUN transition cycle).

Configuration
REQ-029 SHALL use macro FETCH_FAULT_EN.
REQ-030 SHALL, with FETCH_FAULT_EN defined, enter FAULT and set fault=1 when redirect_valid=1 and redirect_pc[1:0]!=0.
REQ-031 SHALL, without FETCH_FAULT_EN, force redirect_pc[1:0] to 0, tie fault=0, and omit the FAULT state.

Structure
REQ-032 SHALL place fetch_entry_t {pc, word}, state enum, NOP_INSN constant in package fetch_pkg.
REQ-033 SHALL implement the queue as sub-module fetch_fifo (2 entries, push/pop/flush, full/empty).

Verification (memory preloaded: 0x0=01000413, 0x4=10100493, 0x8=00848933, rest 0)
REQ-034 SHALL check: reset release, en=1, inst_ready=1 -> inst_pc 0,4,8 with words 01000413,10100493,00848933 on consecutive cycles.
REQ-035 SHALL check: inst_ready=0 for 5 cycles -> FIFO holds pc 0 and 4, fetch stalls at pc=8, head stable 01000413.
REQ-036 SHALL check: redirect_valid=1, redirect_pc=0x8 with full queue -> queue flushed, next valid head pc=8 word 00848933.
REQ-037 SHALL check: run past pc=0x1C -> next inst_pc=0x0 (wrap).
REQ-038 SHALL check (FETCH_FAULT_EN): redirect_pc=0x6 -> fault=1, inst_valid=0 until rst; without macro -> fetch from 0x4.
REQ-039 SHALL check: rst asserted mid-stream with valid head -> inst_valid=0 immediately, restart at pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The FAULT state is only present when FETCH_FAULT_EN is defined.
package fetch_pkg;

  localparam int PC_FIELD_W = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [PC_FIELD_W-1:0] pc;
    logic [31:0]           word;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef FETCH_FAULT_EN
    , FAULT
`endif
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue with push, pop and flush; flush overrides both.
// A push into a full queue is accepted only when the head pops in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect handling and a 2-entry queue.
// Define FETCH_FAULT_EN to trap misaligned redirects in a sticky FAULT state.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              fetch;
  logic              flush;
  logic              pop;
  logic              full;
  logic              empty;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              unused_head_pc;

`ifdef FETCH_FAULT_EN
  logic bad_redirect;
  assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
  assign fault        = (state == FAULT);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign fault               = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en && !redirect_valid) state_nxt = IDLE;
`ifdef FETCH_FAULT_EN
      FAULT:   state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef FETCH_FAULT_EN
    if (bad_redirect) state_nxt = FAULT;
`endif
  end

  // A redirect always flushes; a fetch may refill a full queue only behind a pop.
  always_comb begin
    fetch = 1'b0;
    flush = redirect_valid;
    case (state)
      RUN:     fetch = en && !redirect_valid && (!full || pop);
`ifdef FETCH_FAULT_EN
      FAULT:   flush = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_tgt;
    else if (fetch)          pc <= pc + ADDR_W'(4);
  end

  assign imem_addr       = pc;
  assign push_entry.pc   = PC_FIELD_W'(pc);
  assign push_entry.word = imem_dout;
  assign pop             = inst_valid && inst_ready;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign unused_head_pc = ^head.pc;
  assign inst_valid     = !empty;
  assign inst_word      = empty ? NOP_INSN : head.word;
  assign inst_pc        = empty ? '0 : head.pc[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, back-pressure, redirect, wrap and reset.
// The misaligned-redirect step checks either behaviour depending on FETCH_FAULT_EN.
module tb_fetch_ctrl;

  localparam int ADDR_W = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_dout;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic              fault;

  logic [31:0] mem [8];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr[4:2]];

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .fault          (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic rdy, input logic rv,
                               input logic [ADDR_W-1:0] rpc);
    en             = e;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    mem = '{32'h01000413, 32'h10100493, 32'h00848933, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    repeat (2) tick();
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_pc",    32'(inst_pc),    32'd0);
    checkOutput("rst_word",  inst_word,       NOP);
    checkOutput("rst_fault", 32'(fault),      32'd0);
    checkOutput("rst_addr",  32'(imem_addr),  32'd0);

    // Streaming with decode always ready: one instruction per cycle.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    checkOutput("first_edge_valid", 32'(inst_valid), 32'd0);
    checkOutput("first_edge_addr",  32'(imem_addr),  32'd0);
    tick();
    checkOutput("s0_pc",   32'(inst_pc), 32'h0);
    checkOutput("s0_word", inst_word,    32'h01000413);
    tick();
    checkOutput("s1_pc",   32'(inst_pc), 32'h4);
    checkOutput("s1_word", inst_word,    32'h10100493);
    tick();
    checkOutput("s2_pc",   32'(inst_pc), 32'h8);
    checkOutput("s2_word", inst_word,    32'h00848933);
    checkOutput("s2_valid", 32'(inst_valid), 32'd1);

    // Asynchronous reset with a valid head.
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
    checkOutput("midrst_pc",    32'(inst_pc),    32'd0);
    checkOutput("midrst_word",  inst_word,       NOP);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;

    // Back-pressure: queue fills with pc 0 and 4, fetch stalls at 8.
    tick();
    tick();
    checkOutput("restart_pc", 32'(inst_pc), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_pc",   32'(inst_pc),   32'h0);
      checkOutput("stall_word", inst_word,      32'h01000413);
      checkOutput("stall_addr", 32'(imem_addr), 32'h8);
    end

    // Pop once while full: push and pop together, head advances to pc 4.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    checkOutput("fullpop_pc",   32'(inst_pc), 32'h4);
    checkOutput("fullpop_word", inst_word,    32'h10100493);

    // Redirect to 0x8 with a full queue and a head being accepted.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h08);
    tick();
    checkOutput("redir_flush", 32'(inst_valid), 32'd0);
    checkOutput("redir_addr",  32'(imem_addr),  32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    checkOutput("redir_valid", 32'(inst_valid), 32'd1);
    checkOutput("redir_pc",    32'(inst_pc),    32'h8);
    checkOutput("redir_word",  inst_word,       32'h00848933);

    // Run through 0x1C and wrap to 0x0.
    for (int k = 1; k < 8; k++) begin
      tick();
      exp_pc = (32'h8 + 32'(4 * k)) % 32'd32;
      checkOutput("wrap_pc",   32'(inst_pc), exp_pc);
      checkOutput("wrap_word", inst_word,    mem[exp_pc[4:2]]);
    end

    // Misaligned redirect to 0x6.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'h06);
    tick();
`ifdef FETCH_FAULT_EN
    checkOutput("fault_set",   32'(fault),      32'd1);
    checkOutput("fault_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (3) tick();
    checkOutput("fault_sticky", 32'(fault),      32'd1);
    checkOutput("fault_hold",   32'(inst_valid), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("fault_clear", 32'(fault), 32'd0);
    tick();
    rst = 1'b0;
`else
    checkOutput("misal_fault", 32'(fault),      32'd0);
    checkOutput("misal_flush", 32'(inst_valid), 32'd0);
    checkOutput("misal_addr",  32'(imem_addr),  32'h4);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    checkOutput("misal_pc",   32'(inst_pc), 32'h4);
    checkOutput("misal_word", inst_word,    32'h10100493);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
